// File: rtl/cpu16_bus_target_if.sv
// cpu16_bus_target_if
//  CPU16 word bus between the CPU (master) and the bus target (slave).
//  Signals:
//   address   16  word address from the CPU
//   data_out  16  CPU write data
//   write     1   write strobe; one write per clk edge while high
//   data_in   16  registered read data returned to the CPU
//  Modports: master (CPU side), slave (target side).
interface cpu16_bus_target_if;
  logic [15:0] address;
  logic [15:0] data_out;
  logic        write;
  logic [15:0] data_in;

  modport master (
    output address,
    output data_out,
    output write,
    input  data_in
  );

  modport slave (
    input  address,
    input  data_out,
    input  write,
    output data_in
  );
endinterface

// File: rtl/cpu16_bus_target.sv
// cpu16_bus_target
//  Bus responder for the CPU16: word RAM, an I/O page at 0xFF00..0xFFFF and a
//  keyboard FIFO. Read data comes back one clock after the address (the single
//  RAM wait state the CPU inserts).
//  Ports:
//   clk        single clock, all logic on posedge
//   reset      synchronous, active-high
//   bus        cpu16_bus_target_if.slave (address, data_out, write -> data_in)
//   keycode    FIFO head, 8'h00 when empty
//   keystrobe  CPU key acknowledge; rising edge pops one entry
//   kb_code    keycode from the keyboard front end
//   kb_valid   one-cycle push strobe for kb_code
//  Optional feature macro: CPU16_BUS_WPROT_EN
//   When defined, RAM writes to 0x4000..0x7FFF are dropped and set a sticky
//   wp_err readable at 0xFF03 (any write to 0xFF03 clears it).
module cpu16_bus_target #(
  parameter int RAM_AW    = 15,
  parameter int KEY_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  cpu16_bus_target_if.slave bus,
  output logic [7:0]        keycode,
  input  logic              keystrobe,
  input  logic [7:0]        kb_code,
  input  logic              kb_valid
);
  localparam int         PW     = (KEY_DEPTH > 1) ? $clog2(KEY_DEPTH) : 1;
  localparam logic [4:0] DEPTH5 = 5'(KEY_DEPTH);

  typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_IO} rd_src_e;

  // ---------------- address decode ----------------
  logic in_ram, in_io, ram_we, flush;
  assign in_ram = (bus.address >> RAM_AW) == 16'd0;
  assign in_io  = bus.address[15:8] == 8'hFF;
  assign flush  = bus.write && (bus.address == 16'hFF01);

`ifdef CPU16_BUS_WPROT_EN
  logic in_prog, wp_err_q, wp_err_d;
  assign in_prog = bus.address[15:14] == 2'b01;
  assign ram_we  = bus.write && in_ram && !in_prog;

  always_comb begin
    wp_err_d = wp_err_q;
    if (bus.write && bus.address == 16'hFF03)
      wp_err_d = 1'b0;
    else if (bus.write && in_ram && in_prog)
      wp_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) wp_err_q <= 1'b0;
    else       wp_err_q <= wp_err_d;
  end
`else
  assign ram_we = bus.write && in_ram;
`endif

  // ---------------- word RAM ----------------
  // Kept free of reset so it maps onto block RAM; the read port is plain
  // registered, which gives old data on a same-address read-during-write.
  logic [15:0] mem [2**RAM_AW];
  logic [15:0] ram_rd_q;

  always_ff @(posedge clk) begin
    if (ram_we && !reset)
      mem[bus.address[RAM_AW-1:0]] <= bus.data_out;
    ram_rd_q <= mem[bus.address[RAM_AW-1:0]];
  end

  // ---------------- keyboard FIFO ----------------
  logic [7:0]    kf_q [KEY_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          ks_q;
  logic          full, pop, push;

  assign full = count_q == DEPTH5;
  assign pop  = keystrobe && !ks_q && (count_q != 5'd0);
  // A same-cycle pop frees a slot, so a full FIFO still accepts the push.
  assign push = kb_valid && (!full || pop);

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = 5'd0;
      overflow_d = 1'b0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 5'd1;
        2'b01:   count_d = count_q - 5'd1;
        default: count_d = count_q;
      endcase
      if (kb_valid && full && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= 5'd0;
      overflow_q <= 1'b0;
      ks_q       <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      ks_q       <= keystrobe;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !reset)
      kf_q[wr_ptr_q] <= kb_code;
  end

  assign keycode = (count_q != 5'd0) ? kf_q[rd_ptr_q] : 8'h00;

  // ---------------- tick counter ----------------
  logic [15:0] tick_q;
  always_ff @(posedge clk) begin
    if (reset) tick_q <= 16'd0;
    else       tick_q <= tick_q + 16'd1;
  end

  // ---------------- read path ----------------
  logic [15:0] io_rd_d, io_rd_q;
  rd_src_e     src_d, src_q;

  always_comb begin
    io_rd_d = 16'h0000;
    case (bus.address[7:0])
      8'h00:   io_rd_d = {8'h00, keycode};
      8'h01:   io_rd_d = {overflow_q, 10'b0, count_q};
      8'h02:   io_rd_d = tick_q;
`ifdef CPU16_BUS_WPROT_EN
      8'h03:   io_rd_d = {15'b0, wp_err_q};
`endif
      default: io_rd_d = 16'h0000;
    endcase
  end

  always_comb begin
    src_d = SRC_ZERO;
    if (in_ram)     src_d = SRC_RAM;
    else if (in_io) src_d = SRC_IO;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q   <= SRC_ZERO;
      io_rd_q <= 16'h0000;
    end else begin
      src_q   <= src_d;
      io_rd_q <= io_rd_d;
    end
  end

  // Output select is driven purely by registers, so data_in is stable for the
  // whole cycle after the edge; reset forces the zero source.
  always_comb begin
    case (src_q)
      SRC_RAM: bus.data_in = ram_rd_q;
      SRC_IO:  bus.data_in = io_rd_q;
      default: bus.data_in = 16'h0000;
    endcase
  end
endmodule

// File: tb/tb_cpu16_bus_target.sv
// tb_cpu16_bus_target
//  Directed bench for cpu16_bus_target: RAM read/write timing, unmapped space,
//  keyboard FIFO behaviour, flush, optional write protection, reset during a
//  write and tick wrap. Inputs change 1 time unit after the rising edge and
//  outputs are sampled at that same point, i.e. away from the active edge.
module tb_cpu16_bus_target;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] keycode;
  logic       keystrobe;
  logic [7:0] kb_code;
  logic       kb_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu16_bus_target_if bus_if ();

  cpu16_bus_target dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if),
    .keycode   (keycode),
    .keystrobe (keystrobe),
    .kb_code   (kb_code),
    .kb_valid  (kb_valid)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%04h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
    bus_if.address  = addr;
    bus_if.data_out = data;
    bus_if.write    = 1'b1;
    step();
    bus_if.write    = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    bus_if.address = addr;
    bus_if.write   = 1'b0;
    step();
    check_eq(tag, bus_if.data_in, exp);
  endtask

  task automatic push_key(input logic [7:0] code);
    kb_code  = code;
    kb_valid = 1'b1;
    step();
    kb_valid = 1'b0;
  endtask

  task automatic pop_key();
    keystrobe = 1'b0;
    step();
    keystrobe = 1'b1;
    step();
  endtask

  initial begin
    reset           = 1'b1;
    bus_if.address  = 16'h0000;
    bus_if.data_out = 16'h0000;
    bus_if.write    = 1'b0;
    keystrobe       = 1'b0;
    kb_code         = 8'h00;
    kb_valid        = 1'b0;

    // reset state
    step();
    step();
    check_eq("rst_data_in", bus_if.data_in, 16'h0000);
    check_eq("rst_keycode", {8'h00, keycode}, 16'h0000);
    reset = 1'b0;
    bus_read("rst_status", 16'hFF01, 16'h0000);

    // 1: write then read, one-clock latency
    bus_write(16'h0020, 16'h1111);
    bus_write(16'h0010, 16'h1234);
    bus_read("rd_0020", 16'h0020, 16'h1111);
    bus_read("rd_0010_lat1", 16'h0010, 16'h1234);

    // 2: read-during-write returns old data
    bus_if.address  = 16'h0010;
    bus_if.data_out = 16'hBEEF;
    bus_if.write    = 1'b1;
    step();
    bus_if.write    = 1'b0;
    check_eq("rdw_old", bus_if.data_in, 16'h1234);
    bus_read("rdw_new", 16'h0010, 16'hBEEF);

    // unmapped space and boundaries
    bus_write(16'h1000, 16'h0A0A);
    bus_write(16'h9000, 16'h7777);
    bus_read("unmapped_rd", 16'h9000, 16'h0000);
    bus_read("no_alias", 16'h1000, 16'h0A0A);
    bus_write(16'h3FFF, 16'h3C3C);
    bus_read("rd_3fff", 16'h3FFF, 16'h3C3C);
    bus_read("rd_8000", 16'h8000, 16'h0000);
    bus_read("io_unlisted", 16'hFF10, 16'h0000);

    // 3: held keystrobe pops once
    push_key(8'hA0);
    push_key(8'h41);
    check_eq("kc_head_a0", {8'h00, keycode}, 16'h00A0);
    bus_read("kb_count2", 16'hFF01, 16'h0002);
    bus_read("kb_ff00_nopop", 16'hFF00, 16'h00A0);
    check_eq("kc_still_a0", {8'h00, keycode}, 16'h00A0);
    keystrobe = 1'b1;
    step();
    check_eq("kc_pop1", {8'h00, keycode}, 16'h0041);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("kc_held", {8'h00, keycode}, 16'h0041);
    end
    pop_key();
    check_eq("kc_empty", {8'h00, keycode}, 16'h0000);
    keystrobe = 1'b0;
    step();

    // 4: overflow and flush
    push_key(8'h11);
    push_key(8'h22);
    push_key(8'h33);
    push_key(8'h44);
    push_key(8'h55);
    bus_read("ovf_status", 16'hFF01, 16'h8004);
    check_eq("ovf_head", {8'h00, keycode}, 16'h0011);
    bus_write(16'hFF01, 16'h1234);
    bus_read("flush_status", 16'hFF01, 16'h0000);
    check_eq("flush_keycode", {8'h00, keycode}, 16'h0000);

    // 5: full FIFO, push and pop in the same clock
    push_key(8'h11);
    push_key(8'h22);
    push_key(8'h33);
    push_key(8'h44);
    kb_code   = 8'h55;
    kb_valid  = 1'b1;
    keystrobe = 1'b1;
    step();
    kb_valid  = 1'b0;
    check_eq("full_pp_head", {8'h00, keycode}, 16'h0022);
    bus_read("full_pp_status", 16'hFF01, 16'h0004);
    pop_key();
    check_eq("full_pp_pop33", {8'h00, keycode}, 16'h0033);
    pop_key();
    check_eq("full_pp_pop44", {8'h00, keycode}, 16'h0044);
    pop_key();
    check_eq("full_pp_tail55", {8'h00, keycode}, 16'h0055);
    pop_key();
    check_eq("drain_empty", {8'h00, keycode}, 16'h0000);
    pop_key();
    check_eq("pop_empty_noop", {8'h00, keycode}, 16'h0000);
    bus_read("pop_empty_status", 16'hFF01, 16'h0000);
    keystrobe = 1'b0;
    step();

    // flush wins over a same-cycle push and pop
    push_key(8'h66);
    bus_if.address  = 16'hFF01;
    bus_if.write    = 1'b1;
    kb_code         = 8'h67;
    kb_valid        = 1'b1;
    keystrobe       = 1'b1;
    step();
    bus_if.write    = 1'b0;
    kb_valid        = 1'b0;
    keystrobe       = 1'b0;
    bus_read("flush_beats_pp", 16'hFF01, 16'h0000);
    check_eq("flush_beats_kc", {8'h00, keycode}, 16'h0000);

    // 6: program-area write protection
    bus_write(16'h4000, 16'h5555);
    bus_if.address = 16'h4000;
    step();
`ifdef CPU16_BUS_WPROT_EN
    check_eq("wp_mem_blocked", {15'b0, bus_if.data_in == 16'h5555}, 16'h0000);
    bus_read("wp_err_set", 16'hFF03, 16'h0001);
    bus_write(16'hFF03, 16'h0000);
    bus_read("wp_err_clr", 16'hFF03, 16'h0000);
`else
    check_eq("wp_mem_written", bus_if.data_in, 16'h5555);
    bus_read("wp_reg_zero", 16'hFF03, 16'h0000);
`endif

    // reset asserted during a write
    push_key(8'h77);
    check_eq("pre_rst_kc", {8'h00, keycode}, 16'h0077);
    reset           = 1'b1;
    bus_if.address  = 16'h0010;
    bus_if.data_out = 16'hCAFE;
    bus_if.write    = 1'b1;
    step();
    reset           = 1'b0;
    bus_if.write    = 1'b0;
    check_eq("rst_mid_data_in", bus_if.data_in, 16'h0000);
    check_eq("rst_mid_kc", {8'h00, keycode}, 16'h0000);
    bus_read("rst_mid_word", 16'h0010, 16'hBEEF);

    // tick wrap
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus_read("tick_0", 16'hFF02, 16'h0000);
    for (int i = 0; i < 65534; i++) step();
    check_eq("tick_fffe", bus_if.data_in, 16'hFFFE);
    step();
    check_eq("tick_ffff", bus_if.data_in, 16'hFFFF);
    step();
    check_eq("tick_wrap", bus_if.data_in, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
